// File: rtl/pipe_pkg.sv
// Shared pipeline types for the fetch/decode boundary.
package pipe_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;

  typedef logic [XLEN_DEFAULT-1:0] instr_t;
  typedef logic [XLEN_DEFAULT-1:0] pc_t;

  typedef struct packed {
    instr_t instr;
    pc_t    pc;
  } fq_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Fetch-to-decode instruction FIFO with early stall and flush-with-drop of the in-flight slot.
// Optional FETCH_QUEUE_BYPASS_EN: zero-latency pass-through when the queue is empty.
module fetch_queue
  import pipe_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned XLEN  = XLEN_DEFAULT
) (
  input  logic                     CLK,
  input  logic                     RSTN,
  input  logic                     IN_VALID,
  input  logic [XLEN-1:0]          IN_INSTR,
  input  logic [XLEN-1:0]          IN_PC,
  output logic                     STALL_OUT,
  input  logic                     FLUSH,
  output logic                     OUT_VALID,
  output logic [XLEN-1:0]          OUT_INSTR,
  output logic [XLEN-1:0]          OUT_PC,
  input  logic                     OUT_READY,
  output logic [$clog2(DEPTH):0]   COUNT
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] CntFull = CntW'(DEPTH);
  localparam logic [CntW-1:0] CntSkid = CntW'(DEPTH - 1);

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } entry_t;

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            drop_next_q, drop_next_d;
  entry_t          mem_q [DEPTH];

  logic   full, q_valid, bypass, q_pop, push;
  entry_t head;

  always_comb begin
    full    = (count_q == CntFull);
    q_valid = (count_q != '0) && !FLUSH;
`ifdef FETCH_QUEUE_BYPASS_EN
    bypass  = (count_q == '0) && IN_VALID && !drop_next_q && !FLUSH;
`else
    bypass  = 1'b0;
`endif
    q_pop   = q_valid && OUT_READY;
    // A bypassed instruction taken by decode this cycle never enters storage.
    push    = IN_VALID && !FLUSH && !drop_next_q && (!full || q_pop) && !(bypass && OUT_READY);

    head      = bypass ? entry_t'{instr: IN_INSTR, pc: IN_PC} : mem_q[rd_ptr_q];
    OUT_VALID = q_valid || bypass;
    OUT_INSTR = OUT_VALID ? head.instr : '0;
    OUT_PC    = OUT_VALID ? head.pc    : '0;
    // One skid slot absorbs the instruction fetch issues before it sees the stall.
    STALL_OUT = (count_q >= CntSkid) || FLUSH || !RSTN;
    COUNT     = count_q;
  end

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    drop_next_d = 1'b0;
    if (FLUSH) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      drop_next_d = 1'b1;
    end else begin
      if (push)  wr_ptr_d = wr_ptr_q + 1'b1;
      if (q_pop) rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + CntW'(push) - CntW'(q_pop);
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      drop_next_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      drop_next_q <= drop_next_d;
    end
  end

  // Storage is deliberately not reset; outputs are masked while empty.
  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_ptr_q] <= entry_t'{instr: IN_INSTR, pc: IN_PC};
  end

`ifndef SYNTHESIS
  always_ff @(posedge CLK) begin
    if (RSTN) begin
      assert (!(IN_VALID && !FLUSH && !drop_next_q && full && !q_pop))
        else $error("fetch_queue: instruction arrived while full, dropped");
    end
  end
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed vector table, hand sequences and a queue-based random model.
module tb_fetch_queue;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned XLEN  = 32;
`ifdef FETCH_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic            CLK = 1'b0;
  logic            RSTN;
  logic            IN_VALID;
  logic [XLEN-1:0] IN_INSTR;
  logic [XLEN-1:0] IN_PC;
  logic            STALL_OUT;
  logic            FLUSH;
  logic            OUT_VALID;
  logic [XLEN-1:0] OUT_INSTR;
  logic [XLEN-1:0] OUT_PC;
  logic            OUT_READY;
  logic [2:0]      COUNT;

  always #5 CLK = ~CLK;

  fetch_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .CLK       (CLK),
    .RSTN      (RSTN),
    .IN_VALID  (IN_VALID),
    .IN_INSTR  (IN_INSTR),
    .IN_PC     (IN_PC),
    .STALL_OUT (STALL_OUT),
    .FLUSH     (FLUSH),
    .OUT_VALID (OUT_VALID),
    .OUT_INSTR (OUT_INSTR),
    .OUT_PC    (OUT_PC),
    .OUT_READY (OUT_READY),
    .COUNT     (COUNT)
  );

  int total = 0;
  int bad   = 0;

  // Reference: ordered list of accepted {instr, pc} plus the drop-next flag.
  logic [63:0] mq[$];
  bit          m_drop = 1'b0;

  logic        s_valid, s_stall;
  logic [31:0] s_pc, s_instr;
  logic [2:0]  s_count;
  logic [31:0] popped[$];

  typedef struct {
    bit          iv;
    logic [31:0] pc;
    bit          fl;
    bit          rdy;
    bit          byp;
    bit          ev;
    logic [31:0] epc;
    bit          est;
    int          ecnt;
  } vec_t;

  vec_t tab[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // One clock: drive inputs, check model at negedge, advance model at posedge.
  task automatic cyc(input bit iv, input logic [31:0] pc, input bit fl, input bit rdy);
    bit          byp, ev, pop, acc;
    logic [31:0] epc;
    IN_VALID  = iv;
    IN_PC     = pc;
    IN_INSTR  = ~pc;
    FLUSH     = fl;
    OUT_READY = rdy;
    @(negedge CLK);
    byp = BYP && (mq.size() == 0) && iv && !m_drop && !fl;
    ev  = byp || ((mq.size() != 0) && !fl);
    epc = byp ? pc : (ev ? mq[0][31:0] : 32'h0);
    s_valid = OUT_VALID;
    s_stall = STALL_OUT;
    s_pc    = OUT_PC;
    s_instr = OUT_INSTR;
    s_count = COUNT;
    if (OUT_VALID && rdy) popped.push_back(OUT_PC);
    chk("model_valid", 32'(OUT_VALID), 32'(ev));
    chk("model_pc", OUT_PC, epc);
    chk("model_instr", OUT_INSTR, ev ? ~epc : 32'h0);
    chk("model_stall", 32'(STALL_OUT), 32'((mq.size() >= DEPTH - 1) || fl));
    chk("model_count", 32'(COUNT), 32'(mq.size()));
    @(posedge CLK);
    if (fl) begin
      mq.delete();
      m_drop = 1'b1;
    end else begin
      pop = ev && rdy;
      if (iv && !m_drop && (mq.size() == DEPTH) && !pop) begin
        bad++;
        $display("FAIL invariant: input arrived while full, got count %0d want <%0d",
                 mq.size(), DEPTH);
      end
      acc = iv && !m_drop && ((mq.size() < DEPTH) || pop) && !(byp && rdy);
      if (pop && !byp) void'(mq.pop_front());
      if (acc) mq.push_back({~pc, pc});
      m_drop = 1'b0;
    end
    #1;
  endtask

  initial begin
    bit prev_stall, prev_fl, iv, fl, rdy;
    logic [31:0] pc;

    RSTN = 1'b0; IN_VALID = 1'b0; IN_PC = '0; IN_INSTR = '0; FLUSH = 1'b0; OUT_READY = 1'b0;
    #3;
    chk("rst_valid", 32'(OUT_VALID), 32'd0);
    chk("rst_stall", 32'(STALL_OUT), 32'd1);
    chk("rst_count", 32'(COUNT), 32'd0);
    chk("rst_pc", OUT_PC, 32'h0);
    chk("rst_instr", OUT_INSTR, 32'h0);
    @(posedge CLK); @(posedge CLK); #1;
    RSTN = 1'b1;
    #1;
    chk("rel_stall", 32'(STALL_OUT), 32'd0);

    //               iv  pc        fl rdy byp ev  epc       st cnt
    tab.push_back('{1, 32'h000, 0, 0, 1, 0, 32'h000, 0, 0}); // fill
    tab.push_back('{1, 32'h004, 0, 0, 0, 1, 32'h000, 0, 1});
    tab.push_back('{1, 32'h008, 0, 0, 0, 1, 32'h000, 0, 2});
    tab.push_back('{1, 32'h00C, 0, 0, 0, 1, 32'h000, 1, 3}); // skid slot
    tab.push_back('{0, 32'h000, 0, 0, 0, 1, 32'h000, 1, 4});
    tab.push_back('{1, 32'h010, 0, 1, 0, 1, 32'h000, 1, 4}); // push+pop while full
    tab.push_back('{0, 32'h000, 0, 1, 0, 1, 32'h004, 1, 4});
    tab.push_back('{0, 32'h000, 0, 1, 0, 1, 32'h008, 1, 3});
    tab.push_back('{0, 32'h000, 0, 1, 0, 1, 32'h00C, 0, 2});
    tab.push_back('{0, 32'h000, 0, 1, 0, 1, 32'h010, 0, 1});
    tab.push_back('{0, 32'h000, 0, 0, 0, 0, 32'h000, 0, 0});
    tab.push_back('{1, 32'h020, 0, 0, 1, 0, 32'h000, 0, 0}); // flush scenario
    tab.push_back('{1, 32'h024, 0, 0, 0, 1, 32'h020, 0, 1});
    tab.push_back('{0, 32'h000, 1, 1, 0, 0, 32'h000, 1, 2});
    tab.push_back('{1, 32'h028, 0, 0, 0, 0, 32'h000, 0, 0}); // in-flight, dropped
    tab.push_back('{1, 32'h100, 0, 0, 1, 0, 32'h000, 0, 0});
    tab.push_back('{0, 32'h000, 0, 1, 0, 1, 32'h100, 0, 1});
    tab.push_back('{0, 32'h000, 0, 0, 0, 0, 32'h000, 0, 0});
    tab.push_back('{1, 32'h200, 0, 0, 1, 0, 32'h000, 0, 0}); // back-to-back flush
    tab.push_back('{0, 32'h000, 1, 0, 0, 0, 32'h000, 1, 1});
    tab.push_back('{1, 32'h204, 1, 0, 0, 0, 32'h000, 1, 0});
    tab.push_back('{1, 32'h208, 0, 0, 0, 0, 32'h000, 0, 0});
    tab.push_back('{0, 32'h000, 0, 0, 0, 0, 32'h000, 0, 0});

    foreach (tab[i]) begin
      bit          ev;
      logic [31:0] epc;
      cyc(tab[i].iv, tab[i].pc, tab[i].fl, tab[i].rdy);
      ev  = tab[i].ev || (BYP && tab[i].byp);
      epc = (BYP && tab[i].byp) ? tab[i].pc : tab[i].epc;
      chk($sformatf("tab%0d_valid", i), 32'(s_valid), 32'(ev));
      chk($sformatf("tab%0d_pc", i), s_pc, epc);
      chk($sformatf("tab%0d_stall", i), 32'(s_stall), 32'(tab[i].est));
      chk($sformatf("tab%0d_count", i), 32'(s_count), 32'(tab[i].ecnt));
    end

    // Pointer wrap: ten push/pop pairs must come out in order exactly once.
    popped.delete();
    for (int i = 0; i < 11; i++) cyc(i < 10, 32'(4 * i), 1'b0, 1'b1);
    chk("wrap_n", 32'(popped.size()), 32'd10);
    for (int i = 0; i < 10; i++)
      chk($sformatf("wrap_%0d", i), (i < popped.size()) ? popped[i] : 32'hDEAD, 32'(4 * i));

    // Asynchronous reset with three entries queued.
    for (int i = 0; i < 3; i++) cyc(1'b1, 32'h300 + 32'(4 * i), 1'b0, 1'b0);
    IN_VALID = 1'b0;
    chk("pre_rst_count", 32'(COUNT), 32'd3);
    #2 RSTN = 1'b0;
    #1;
    chk("async_valid", 32'(OUT_VALID), 32'd0);
    chk("async_count", 32'(COUNT), 32'd0);
    chk("async_stall", 32'(STALL_OUT), 32'd1);
    mq.delete();
    m_drop = 1'b0;
    @(posedge CLK); #1;
    RSTN = 1'b1;
    #1;
    chk("post_rst_stall", 32'(STALL_OUT), 32'd0);
    chk("post_rst_count", 32'(COUNT), 32'd0);

`ifdef FETCH_QUEUE_BYPASS_EN
    cyc(1'b1, 32'h40, 1'b0, 1'b1);
    chk("byp_valid", 32'(s_valid), 32'd1);
    chk("byp_pc", s_pc, 32'h40);
    cyc(1'b0, 32'h0, 1'b0, 1'b0);
    chk("byp_count", 32'(s_count), 32'd0);
`endif

    prev_stall = 1'b0;
    prev_fl    = 1'b0;
    for (int n = 0; n < 400; n++) begin
      // Fetch issues only if it saw no stall last cycle; one in-flight slot after a flush.
      iv  = (!prev_stall || prev_fl) && ($urandom_range(0, 3) != 0);
      fl  = ($urandom_range(0, 15) == 0);
      rdy = ($urandom_range(0, 2) != 0);
      pc  = $urandom & 32'hFFFF_FFFC;
      cyc(iv, pc, fl, rdy);
      prev_stall = s_stall;
      prev_fl    = fl;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
